// File: rtl/decim4x_cic.sv
// decim4x_cic: second-order CIC decimator, R=4, M=1, unity DC gain.
// Brings 192 kHz composite-rate samples back to the 48 kHz audio rate.
module decim4x_cic #(
  parameter int NBITS = 18,
  parameter int GUARD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clkenin,
  input  logic             clkenout,
  input  logic [NBITS-1:0] xkin,
  output logic [NBITS-1:0] ykout,
  output logic             ready,
  output logic             align_err
);

  localparam int W = NBITS + GUARD;

  localparam logic [W:0] HALF =
    (W+1)'(1) << (GUARD-1);

  localparam logic [NBITS-1:0] MAXV =
    {1'b0, {(NBITS-1){1'b1}}};

  localparam logic [NBITS-1:0] MINV =
    {1'b1, {(NBITS-1){1'b0}}};

  localparam logic [2:0] CNT_MAX = 3'd7;
  localparam logic [2:0] CNT_OK  = 3'd4;
  localparam logic [1:0] WU_DONE = 2'd2;

  logic [W-1:0]     i1_q, i1_d;
  logic [W-1:0]     i2_q, i2_d;
  logic [W-1:0]     d1_q, d1_d;
  logic [W-1:0]     d2_q, d2_d;
  logic [1:0]       wu_q, wu_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [NBITS-1:0] y_q, y_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic [W-1:0]     xs;
  logic [W-1:0]     c1;
  logic [W-1:0]     c2;
  logic [W:0]       rnd;
  logic [W:0]       rsh;
  logic [W-NBITS+1:0] top;
  logic [NBITS-1:0] r;

  // Comb section, rounding and output saturation guard
  always_comb begin
    xs  = {{GUARD{xkin[NBITS-1]}}, xkin};
    c1  = i2_q - d1_q;
    c2  = c1 - d2_q;
    rnd = {c2[W-1], c2} + HALF;
    rsh = $signed(rnd) >>> GUARD;
    top = rsh[W:NBITS-1];
    if (&top || ~|top) begin
      r = rsh[NBITS-1:0];
    end else if (rsh[W]) begin
      r = MINV;
    end else begin
      r = MAXV;
    end
  end

  // Integrator cascade, advanced once per input sample
  always_comb begin
    i1_d = i1_q;
    i2_d = i2_q;
    if (clkenin) begin
      i1_d = i1_q + xs;
      i2_d = i2_q + i1_q;
    end
  end

  // Comb delays sampled at each decimation point
  always_comb begin
    d1_d = d1_q;
    d2_d = d2_q;
    if (clkenout) begin
      d1_d = i2_q;
      d2_d = c1;
    end
  end

  // Ratio monitor: input pulses seen since the last decimation point
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clkenout) begin
      cnt_d = {2'b00, clkenin};
      if (wu_q != 2'd0 && cnt_q != CNT_OK) begin
        err_d = 1'b1;
      end
    end else if (clkenin && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Warm-up gating and output register update
  always_comb begin
    wu_d  = wu_q;
    y_d   = y_q;
    rdy_d = 1'b0;
    if (clkenout) begin
      if (wu_q == WU_DONE) begin
        y_d   = r;
        rdy_d = 1'b1;
      end else begin
        wu_d = wu_q + 2'd1;
      end
    end
  end

  // Datapath state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      i1_q <= '0;
      i2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  // Control and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wu_q  <= '0;
      cnt_q <= '0;
      y_q   <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wu_q  <= wu_d;
      cnt_q <= cnt_d;
      y_q   <= y_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
    end
  end

  assign ykout     = y_q;
  assign ready     = rdy_q;
  assign align_err = err_q;

endmodule

// File: tb/tb_decim4x_cic.sv
// tb_decim4x_cic: random/directed stimulus for decim4x_cic
// against a closed-form CIC reference model.
module tb_decim4x_cic;

  logic        clock = 1'b0;
  logic        reset;
  logic        clkenin;
  logic        clkenout;
  logic [17:0] xkin;
  logic [17:0] ykout;
  logic        ready;
  logic        align_err;

  always #5 clock = ~clock;

  decim4x_cic dut (
    .clock    (clock),
    .reset    (reset),
    .clkenin  (clkenin),
    .clkenout (clkenout),
    .xkin     (xkin),
    .ykout    (ykout),
    .ready    (ready),
    .align_err(align_err)
  );

  int checks = 0;
  int failures = 0;

  longint xs[$];
  int     nl[$];
  int     k;
  longint ey;
  bit     erdy;
  bit     eerr;
  int     rc;
  int     ph;
  bit     late;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  // second integrator value after n samples,
  // as a weighted sum of the input history
  function automatic longint s2(input int n);
    longint acc = 0;
    for (int j = 0; j <= n - 2; j++)
      acc += xs[j] * longint'(n - 1 - j);
    return acc;
  endfunction

  function automatic longint fdiv16(input longint v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic longint sat18(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic cyc(input bit r, input bit ei,
                     input bit eo, input int x);
    int n, p, pp;
    longint c2;
    reset    = r;
    clkenin  = ei;
    clkenout = eo;
    xkin     = 18'(x);
    @(posedge clock);
    if (r) begin
      xs.delete();
      nl.delete();
      k = 0;
      ey = 0;
      erdy = 0;
      eerr = 0;
    end else begin
      erdy = 0;
      if (eo) begin
        n  = xs.size();
        p  = (nl.size() > 0) ? nl[nl.size()-1] : 0;
        pp = (nl.size() > 1) ? nl[nl.size()-2] : 0;
        c2 = s2(n) - 2 * s2(p) + s2(pp);
        if (k >= 1 && n - p != 4) eerr = 1;
        k++;
        nl.push_back(n);
        if (k >= 3) begin
          ey = sat18(fdiv16(c2 + 8));
          erdy = 1;
        end
      end
      if (ei) xs.push_back(longint'(x));
    end
    #1;
    chk("ready", ready, erdy);
    chk("ykout", $signed(ykout), ey);
    chk("align", align_err, eerr);
    if (ready === 1'b1) rc++;
  endtask

  task automatic rst(input int n);
    repeat (n)
      cyc(1, 1'($urandom), 1'($urandom),
          int'($urandom));
    ph = 0;
    rc = 0;
  endtask

  task automatic samp(input int x, input int gap);
    bit eo;
    eo = (!late && ph == 3);
    cyc(0, 1, eo, x);
    ph = (ph == 3) ? 0 : ph + 1;
    if (late && ph == 0) cyc(0, 0, 1, 0);
    repeat ($urandom_range(gap, 0))
      cyc(0, 0, 0, int'($urandom));
  endtask

  function automatic int rnd18();
    return int'($urandom_range(262143, 0)) - 131072;
  endfunction

  initial begin
    ph = 0;
    late = 0;
    rc = 0;
    rst(3);
    chk("rst_y", $signed(ykout), 0);
    chk("rst_err", align_err, 0);

    for (int i = 0; i < 40; i++) samp(1000, 2);
    chk("dc1000", $signed(ykout), 1000);
    chk("dc_rate", rc, 8);

    for (int i = 0; i < 40; i++) samp(-131072, 1);
    chk("negfs", $signed(ykout), -131072);

    for (int i = 0; i < 40; i++)
      samp((i % 2 == 0) ? 20000 : -20000, 2);
    chk("null", $signed(ykout), 0);

    for (int i = 0; i < 40; i++) samp(131071, 1);
    chk("posfs", $signed(ykout), 131071);
    chk("no_err", align_err, 0);

    rst(2);
    for (int i = 0; i < 80; i++) samp(rnd18(), 2);

    rst(2);
    late = 1;
    for (int i = 0; i < 40; i++) samp(rnd18(), 1);
    chk("late_rate", rc, 8);
    late = 0;

    rst(2);
    for (int i = 0; i < 16; i++) samp(1000, 1);
    chk("pre_err", align_err, 0);
    cyc(0, 1, 0, 1000);
    for (int i = 0; i < 16; i++) samp(1000, 1);
    chk("align_set", align_err, 1);
    rst(1);
    chk("align_clr", align_err, 0);

    for (int i = 0; i < 48; i++) samp(5000, 2);
    chk("mid_5000", $signed(ykout), 5000);
    chk("mid_rate", rc, 10);
    rst(1);
    chk("mid_rst_y", $signed(ykout), 0);
    for (int i = 0; i < 40; i++) samp(0, 2);
    chk("zero_rate", rc, 8);
    chk("zero_y", $signed(ykout), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
